// File: rtl/core_block_launcher.sv
// core_block_launcher
//   Compute-unit end of the block-dispatch handshake, one instance per core.
//   Takes a block assignment (core_start + core_block_id), works out how many
//   threads of the kernel fall inside that block, and splits them into
//   WARP_SIZE-thread warps. Each warp goes to the warp scheduler over a
//   valid/ready channel. The block launcher then counts warp retirements and
//   raises core_done until the dispatcher releases core_start.
//
// Ports
//   clk, rst_n          clock (posedge) and synchronous active-low reset
//   core_start          dispatcher level request, held until core_done is seen
//   core_block_id       signed block index; negative means no block
//   num_threads         total kernel threads (static during a kernel)
//   block_dim           threads per block (static during a kernel)
//   core_done           block finished (level)
//   warp_valid/ready    warp descriptor handshake with the scheduler
//   warp_id             warp index within the block
//   warp_base_tid       global thread id of lane 0
//   warp_mask           active lanes, bit i = lane i
//   warp_done           one-cycle pulse per retired warp
//   busy                launcher is not idle
//   err_oversize        sticky: a block needed more than MAX_WARPS warps
module core_block_launcher #(
  parameter int WARP_SIZE = 32,
  parameter int MAX_WARPS = 32,
  parameter int WARP_ID_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 core_start,
  input  logic signed [31:0]   core_block_id,
  input  logic [31:0]          num_threads,
  input  logic [31:0]          block_dim,
  output logic                 core_done,
  output logic                 warp_valid,
  input  logic                 warp_ready,
  output logic [WARP_ID_W-1:0] warp_id,
  output logic [31:0]          warp_base_tid,
  output logic [WARP_SIZE-1:0] warp_mask,
  input  logic                 warp_done,
  output logic                 busy,
  output logic                 err_oversize
);

  localparam int LOG_WS = $clog2(WARP_SIZE);
  localparam int CNT_W  = $clog2(MAX_WARPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] issued, issued_n;
  logic [CNT_W-1:0] retired, retired_n;

  // Per-block values; they are only meaningful outside IDLE, so they carry
  // no reset.
  logic [31:0]      id_q;
  logic [31:0]      base;
  logic [31:0]      nthr;
  logic [CNT_W-1:0] nw;

  // Block geometry, evaluated during SETUP from the latched block id.
  logic [31:0]      setup_base;
  logic [31:0]      setup_room;
  logic [31:0]      setup_nthr;
  logic [32:0]      setup_nw_full;
  logic             setup_clamp;
  logic [CNT_W-1:0] setup_nw;

  always_comb begin
    setup_base = id_q * block_dim;
    setup_room = num_threads - setup_base;
    if (setup_base >= num_threads) begin
      setup_nthr = '0;
    end else if (block_dim < setup_room) begin
      setup_nthr = block_dim;
    end else begin
      setup_nthr = setup_room;
    end
    // 33-bit sum so the ceiling cannot wrap for thread counts near 2^32.
    setup_nw_full = ({1'b0, setup_nthr} + 33'(WARP_SIZE - 1)) >> LOG_WS;
    setup_clamp   = setup_nw_full > 33'(MAX_WARPS);
    setup_nw      = setup_clamp ? CNT_W'(MAX_WARPS) : setup_nw_full[CNT_W-1:0];
  end

  // Current descriptor. Lane i is live while it lies inside the block's
  // thread range, i.e. while i is below the threads still left for this warp.
  logic [31:0]          issue_off;
  logic [31:0]          lane_room;
  logic [WARP_SIZE-1:0] lane_mask;
  logic                 hs;
  logic [CNT_W-1:0]     issued_inc;
  logic [CNT_W-1:0]     retired_inc;

  always_comb begin
    issue_off = 32'(issued) << LOG_WS;
    lane_room = nthr - issue_off;
    lane_mask = '0;
    for (int i = 0; i < WARP_SIZE; i++) begin
      lane_mask[i] = lane_room > 32'(i);
    end
  end

  assign hs          = (state == S_ISSUE) && warp_ready;
  assign issued_inc  = issued + CNT_W'(1);
  assign retired_inc = retired + CNT_W'(warp_done);

  always_comb begin
    state_n   = state;
    issued_n  = issued;
    retired_n = retired;
    case (state)
      S_IDLE: begin
        issued_n  = '0;
        retired_n = '0;
        if (core_start && (core_block_id >= 0)) begin
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!core_start) begin
          state_n = S_IDLE;
        end else if (setup_nw == '0) begin
          state_n = S_DONE;
        end else begin
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!core_start) begin
          state_n   = S_IDLE;
          issued_n  = '0;
          retired_n = '0;
        end else begin
          retired_n = retired_inc;
          if (hs) begin
            issued_n = issued_inc;
            // A retirement landing on the final handshake can finish the
            // block outright, skipping WAIT.
            if (issued_inc == nw) begin
              state_n = (retired_inc >= nw) ? S_DONE : S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (!core_start) begin
          state_n   = S_IDLE;
          issued_n  = '0;
          retired_n = '0;
        end else begin
          retired_n = retired_inc;
          if (retired_inc >= nw) begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!core_start) begin
          state_n   = S_IDLE;
          issued_n  = '0;
          retired_n = '0;
        end
      end
      default: begin
        state_n   = S_IDLE;
        issued_n  = '0;
        retired_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      issued       <= '0;
      retired      <= '0;
      err_oversize <= 1'b0;
    end else begin
      state   <= state_n;
      issued  <= issued_n;
      retired <= retired_n;
      if ((state == S_SETUP) && setup_clamp) begin
        err_oversize <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      id_q <= $unsigned(core_block_id);
    end
    if (state == S_SETUP) begin
      base <= setup_base;
      nthr <= setup_nthr;
      nw   <= setup_nw;
    end
  end

  assign warp_valid    = (state == S_ISSUE);
  assign warp_id       = warp_valid ? issued[WARP_ID_W-1:0] : '0;
  assign warp_base_tid = warp_valid ? (base + issue_off) : '0;
  assign warp_mask     = warp_valid ? lane_mask : '0;
  assign core_done     = (state == S_DONE);
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_core_block_launcher.sv
// tb_core_block_launcher
//   Randomized bench for core_block_launcher. A behavioural model tracks a
//   block as "started / edges since start / handshakes / retirements" and
//   derives every expected output from the block arithmetic directly.
module tb_core_block_launcher;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               core_start = 1'b0;
  logic signed [31:0] core_block_id = '0;
  logic [31:0]        num_threads = '0;
  logic [31:0]        block_dim = '0;
  logic               core_done;
  logic               warp_valid;
  logic               warp_ready = 1'b0;
  logic [4:0]         warp_id;
  logic [31:0]        warp_base_tid;
  logic [31:0]        warp_mask;
  logic               warp_done = 1'b0;
  logic               busy;
  logic               err_oversize;

  always #5 clk = ~clk;

  core_block_launcher #(
    .WARP_SIZE(32),
    .MAX_WARPS(32),
    .WARP_ID_W(5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_start   (core_start),
    .core_block_id(core_block_id),
    .num_threads  (num_threads),
    .block_dim    (block_dim),
    .core_done    (core_done),
    .warp_valid   (warp_valid),
    .warp_ready   (warp_ready),
    .warp_id      (warp_id),
    .warp_base_tid(warp_base_tid),
    .warp_mask    (warp_mask),
    .warp_done    (warp_done),
    .busy         (busy),
    .err_oversize (err_oversize)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  bit              m_started = 0;
  int              m_cyc = 0;
  int              m_hs = 0;
  int              m_ret = 0;
  bit              m_err = 0;
  bit              m_clamp = 0;
  longint unsigned m_base = 0;
  longint unsigned m_nthr = 0;
  int              m_nw = 0;

  function automatic void m_setup(input logic [31:0] id, input logic [31:0] nt, input logic [31:0] bd);
    logic [31:0]     b;
    longint unsigned t;
    b = id * bd;
    if (b >= nt) t = 0;
    else if (bd < nt - b) t = bd;
    else t = nt - b;
    m_base  = b;
    m_nthr  = t;
    m_nw    = int'((t + 31) / 32);
    m_clamp = (m_nw > 32);
    if (m_clamp) m_nw = 32;
  endfunction

  function automatic bit m_done();
    return m_started && (m_cyc >= 2) && ((m_nw == 0) || ((m_hs == m_nw) && (m_ret == m_nw)));
  endfunction

  function automatic bit m_valid();
    return m_started && (m_cyc >= 2) && (m_nw > 0) && (m_hs < m_nw);
  endfunction

  // One clock: check outputs at the negedge, drive scheduler inputs, advance
  // the model at the posedge, return to the negedge.
  task automatic tick(input int p_ready, input int p_done);
    bit              ev, ed, hs, cnt_done;
    longint unsigned tid;
    logic [31:0]     emask;
    ev = m_valid();
    ed = m_done();
    check("busy", busy, m_started);
    check("warp_valid", warp_valid, ev);
    check("core_done", core_done, ed);
    check("err_oversize", err_oversize, m_err);
    if (ev) begin
      tid   = m_base + longint'(m_hs) * 32;
      emask = '0;
      for (int i = 0; i < 32; i++) begin
        if (tid + longint'(i) < m_base + m_nthr) emask[i] = 1'b1;
      end
      check("warp_id", warp_id, m_hs);
      check("warp_base_tid", warp_base_tid, tid & 64'hFFFF_FFFF);
      check("warp_mask", warp_mask, emask);
    end
    warp_ready = int'($urandom_range(99)) < p_ready;
    if ((m_hs > m_ret) && (int'($urandom_range(99)) < p_done)) warp_done = 1'b1;
    else if ((!m_started || m_cyc == 1 || ed) && (int'($urandom_range(99)) < 20)) warp_done = 1'b1;
    else warp_done = 1'b0;
    hs       = ev && warp_ready;
    cnt_done = warp_done && m_started && (m_cyc >= 2) && !ed;
    @(posedge clk);
    if (!rst_n) begin
      m_started = 0;
      m_err     = 0;
    end else begin
      if (m_started && m_cyc == 1 && m_clamp) m_err = 1;
      if (core_start) begin
        if (!m_started) begin
          if (core_block_id >= 0) begin
            m_started = 1;
            m_cyc     = 1;
            m_hs      = 0;
            m_ret     = 0;
            m_setup(core_block_id, num_threads, block_dim);
          end
        end else begin
          m_cyc++;
          if (hs) m_hs++;
          if (cnt_done) m_ret++;
        end
      end else begin
        m_started = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_zero();
    check("rst_core_done", core_done, 0);
    check("rst_warp_valid", warp_valid, 0);
    check("rst_warp_id", warp_id, 0);
    check("rst_warp_base_tid", warp_base_tid, 0);
    check("rst_warp_mask", warp_mask, 0);
    check("rst_busy", busy, 0);
    check("rst_err_oversize", err_oversize, 0);
  endtask

  task automatic run_block(input int id, input logic [31:0] nt, input logic [31:0] bd,
                           input int p_ready, input int p_done, input int abort_cyc);
    bit fin;
    core_block_id = id;
    num_threads   = nt;
    block_dim     = bd;
    core_start    = 1'b1;
    fin = 0;
    for (int k = 0; k < 4000 && !fin; k++) begin
      tick(p_ready, p_done);
      if (abort_cyc > 0 && m_started && m_cyc >= abort_cyc) fin = 1;
      if (m_done()) fin = 1;
    end
    if (!fin) check("timeout", 0, 1);
    if (m_done()) repeat (2) tick(p_ready, p_done);
    core_start = 1'b0;
    repeat (3) tick(p_ready, p_done);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero();
    rst_n = 1'b1;
    tick(100, 0);

    run_block(0, 100, 64, 100, 50, 0);
    run_block(1, 100, 64, 100, 50, 0);
    run_block(2, 100, 64, 100, 50, 0);
    run_block(0, 100, 64, 25, 40, 0);
    run_block(1, 100, 64, 100, 100, 0);
    run_block(0, 32'd1 << 20, 2048, 80, 60, 0);
    run_block(0, 100, 64, 100, 0, 10);

    // negative block id is ignored
    core_block_id = -1;
    num_threads   = 100;
    block_dim     = 64;
    core_start    = 1'b1;
    repeat (4) tick(100, 0);
    core_start = 1'b0;
    tick(100, 0);

    // reset in the middle of issuing
    core_block_id = 0;
    num_threads   = 32'd1 << 20;
    block_dim     = 2048;
    core_start    = 1'b1;
    for (int k = 0; k < 10 && !(m_started && m_cyc >= 6); k++) tick(50, 30);
    rst_n      = 1'b0;
    core_start = 1'b0;
    tick(100, 0);
    check_zero();
    rst_n = 1'b1;
    repeat (4) tick(100, 0);

    for (int b = 0; b < 40; b++) begin
      int id, pr, pd, ab;
      logic [31:0] nt, bd;
      id = int'($urandom_range(12));
      bd = ($urandom_range(7) == 0) ? $urandom_range(3000, 1100) : $urandom_range(400, 1);
      nt = $urandom_range(4000);
      pr = int'($urandom_range(100, 20));
      pd = int'($urandom_range(100, 10));
      ab = ($urandom_range(5) == 0) ? int'($urandom_range(20, 1)) : 0;
      run_block(id, nt, bd, pr, pd, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
